// File: rtl/calc_disp_pkg.sv
// calc_disp_pkg
//   Shared constants for the calculator display scanner: active-low segment
//   patterns ordered {g,f,e,d,c,b,a}, blank/off codes, digit count and the
//   snapshot record type.
package calc_disp_pkg;

    localparam int NUM_DIGITS = 8;

    localparam logic [6:0] SEG_BLANK  = 7'h7F;
    localparam logic [7:0] LED_EN_OFF = 8'hFF;
    localparam logic [6:0] SEG_E      = 7'b0000110;
    localparam logic [6:0] SEG_R      = 7'b0101111;

    localparam logic [6:0] SEG_HEX [0:15] = '{
        7'b1000000,   // 0
        7'b1111001,   // 1
        7'b0100100,   // 2
        7'b0110000,   // 3
        7'b0011001,   // 4
        7'b0010010,   // 5
        7'b0000010,   // 6
        7'b1111000,   // 7
        7'b0000000,   // 8
        7'b0010000,   // 9
        7'b0001000,   // A
        7'b0000011,   // b
        7'b1000110,   // C
        7'b0100001,   // d
        7'b0000110,   // E
        7'b0001110    // F
    };

    typedef struct packed {
        logic        err;
        logic [31:0] val;
    } snap_t;

endpackage

// File: rtl/hex_to_seg7.sv
// hex_to_seg7
//   Combinational hex nibble to active-low 7-segment decoder.
//   nib_i : 4-bit digit value
//   seg_o : segments {g,f,e,d,c,b,a}, 0 = lit
module hex_to_seg7
    import calc_disp_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG_HEX[nib_i];

endmodule

// File: rtl/calc_seg_scan.sv
// calc_seg_scan
//   Scans eight common-anode hex digits showing the calculator result.
//   The result/error pair is captured once per frame (at the end of slot 7)
//   so a frame is never torn by input changes.
//   clk         : scan clock
//   rst         : asynchronous reset, active-low
//   cal_result  : 32-bit value to display
//   flag_error  : shows "Err" instead of the value
//   led_en      : digit enables, active-low (FF = all off)
//   led_ca..cg  : segments a..g, active-low
//   led_dp      : decimal point, always off
module calc_seg_scan
    import calc_disp_pkg::*;
#(
    parameter int SCAN_DIV = 20000,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] cal_result,
    input  logic        flag_error,
    output logic [7:0]  led_en,
    output logic        led_ca,
    output logic        led_cb,
    output logic        led_cc,
    output logic        led_cd,
    output logic        led_ce,
    output logic        led_cf,
    output logic        led_cg,
    output logic        led_dp
);

    localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    logic [PW-1:0] presc_q, presc_d;
    logic [2:0]    d_q, d_d;
    snap_t         snap_q, snap_d;
    logic [7:0]    en_q, en_d;
    logic [6:0]    seg_q, seg_d;

    logic          slot_end;
    logic [3:0]    nib;
    logic [6:0]    hex_seg;
    logic [7:0]    lz_mask;
    logic          zero_above;

    assign slot_end = (presc_q == PW'(SCAN_DIV - 1));

    always_comb begin
        presc_d = presc_q + PW'(1);
        d_d     = d_q;
        snap_d  = snap_q;
        if (slot_end) begin
            presc_d = '0;
            d_d     = d_q + 3'd1;
            if (d_q == 3'd7) begin
                snap_d.err = flag_error;
                snap_d.val = cal_result;
            end
        end
    end

    // lz_mask[k] is set when nibbles 7..k are all zero; digit 0 is never blanked
    always_comb begin
        lz_mask    = '0;
        zero_above = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            zero_above = zero_above & (snap_q.val[4*k +: 4] == 4'h0);
            lz_mask[k] = zero_above;
        end
    end

    assign nib = snap_q.val[{d_q, 2'b00} +: 4];

    hex_to_seg7 u_hex_to_seg7 (
        .nib_i (nib),
        .seg_o (hex_seg)
    );

    always_comb begin
        en_d  = ~(8'b1 << d_q);
        seg_d = hex_seg;
        if (snap_q.err) begin
            case (d_q)
                3'd2:       seg_d = SEG_E;
                3'd1, 3'd0: seg_d = SEG_R;
                default: begin
                    en_d  = LED_EN_OFF;
                    seg_d = SEG_BLANK;
                end
            endcase
        end else if (BLANK_LZ && lz_mask[d_q]) begin
            en_d  = LED_EN_OFF;
            seg_d = SEG_BLANK;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_q <= '0;
            d_q     <= '0;
            snap_q  <= '0;
            en_q    <= LED_EN_OFF;
            seg_q   <= SEG_BLANK;
        end else begin
            presc_q <= presc_d;
            d_q     <= d_d;
            snap_q  <= snap_d;
            en_q    <= en_d;
            seg_q   <= seg_d;
        end
    end

    assign led_en = en_q;
    assign {led_cg, led_cf, led_ce, led_cd, led_cc, led_cb, led_ca} = seg_q;
    assign led_dp = 1'b1;

endmodule

// File: tb/tb_calc_seg_scan.sv
// tb_calc_seg_scan
//   Directed bench for calc_seg_scan with SCAN_DIV=4: one instance with
//   leading-zero blanking, one without, sharing clock, reset and inputs.
module tb_calc_seg_scan;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] cal_result = '0;
    logic        flag_error = 1'b0;

    logic [7:0]  en_a, en_b;
    logic        ca_a, cb_a, cc_a, cd_a, ce_a, cf_a, cg_a, dp_a;
    logic        ca_b, cb_b, cc_b, cd_b, ce_b, cf_b, cg_b, dp_b;

    int n_chk  = 0;
    int n_pass = 0;

    // expected per slot: index 0 = blanking instance, 1 = no-blanking instance
    logic [7:0] e_en  [2][8];
    logic [6:0] e_seg [2][8];

    calc_seg_scan #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) dut (
        .clk(clk), .rst(rst), .cal_result(cal_result), .flag_error(flag_error),
        .led_en(en_a), .led_ca(ca_a), .led_cb(cb_a), .led_cc(cc_a), .led_cd(cd_a),
        .led_ce(ce_a), .led_cf(cf_a), .led_cg(cg_a), .led_dp(dp_a)
    );

    calc_seg_scan #(.SCAN_DIV(4), .BLANK_LZ(1'b0)) dut_nb (
        .clk(clk), .rst(rst), .cal_result(cal_result), .flag_error(flag_error),
        .led_en(en_b), .led_ca(ca_b), .led_cb(cb_b), .led_cc(cc_b), .led_cd(cd_b),
        .led_ce(ce_b), .led_cf(cf_b), .led_cg(cg_b), .led_dp(dp_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    function automatic logic [15:0] obs_a();
        return {en_a, dp_a, cg_a, cf_a, ce_a, cd_a, cc_a, cb_a, ca_a};
    endfunction

    function automatic logic [15:0] obs_b();
        return {en_b, dp_b, cg_b, cf_b, ce_b, cd_b, cc_b, cb_b, ca_b};
    endfunction

    task automatic clr(input int inst);
        for (int d = 0; d < 8; d++) begin
            e_en[inst][d]  = 8'hFF;
            e_seg[inst][d] = 7'h7F;
        end
    endtask

    task automatic dig(input int inst, input int d, input logic [6:0] s);
        e_en[inst][d]  = ~(8'b1 << d);
        e_seg[inst][d] = s;
    endtask

    // Checks the 32 cycles of one frame. Inputs for the next frame are driven
    // before the last edge of this frame, which is the capture edge.
    task automatic check_frame(input string tag, input bit use_nb,
                               input bit mid_en, input logic [31:0] mid_v,
                               input logic [31:0] nxt_v, input logic nxt_e);
        for (int i = 0; i < 32; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("%s s%0d c%0d", tag, i / 4, i % 4), obs_a(),
                {e_en[0][i/4], 1'b1, e_seg[0][i/4]});
            if (use_nb)
                chk($sformatf("%s_nb s%0d c%0d", tag, i / 4, i % 4), obs_b(),
                    {e_en[1][i/4], 1'b1, e_seg[1][i/4]});
            if (mid_en && i == 13) cal_result = mid_v;
            if (i == 30) begin
                cal_result = nxt_v;
                flag_error = nxt_e;
            end
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("reset", obs_a(), {8'hFF, 1'b1, 7'h7F});
        chk("reset_nb", obs_b(), {8'hFF, 1'b1, 7'h7F});
        rst = 1'b1;

        // frame 0: snapshot still zero
        clr(0); dig(0, 0, 7'h40);
        for (int d = 0; d < 8; d++) dig(1, d, 7'h40);
        check_frame("f0_zero", 1'b1, 1'b0, '0, 32'h0000_00A5, 1'b0);

        clr(0); dig(0, 0, 7'h12); dig(0, 1, 7'h08);
        check_frame("f1_a5", 1'b0, 1'b0, '0, 32'h1234_ABCD, 1'b0);

        clr(0);
        dig(0, 0, 7'h21); dig(0, 1, 7'h46); dig(0, 2, 7'h03); dig(0, 3, 7'h08);
        dig(0, 4, 7'h19); dig(0, 5, 7'h30); dig(0, 6, 7'h24); dig(0, 7, 7'h79);
        check_frame("f2_walk", 1'b0, 1'b0, '0, 32'hFFFF_FFFF, 1'b1);

        clr(0); dig(0, 0, 7'h2F); dig(0, 1, 7'h2F); dig(0, 2, 7'h06);
        clr(1); dig(1, 0, 7'h2F); dig(1, 1, 7'h2F); dig(1, 2, 7'h06);
        check_frame("f3_err", 1'b1, 1'b0, '0, 32'h0000_0011, 1'b0);

        clr(0); dig(0, 0, 7'h79); dig(0, 1, 7'h79);
        check_frame("f4_tear", 1'b0, 1'b1, 32'h0000_0022, 32'h0000_0022, 1'b0);

        clr(0); dig(0, 0, 7'h24); dig(0, 1, 7'h24);
        check_frame("f5_22", 1'b0, 1'b0, '0, 32'h0000_0005, 1'b0);

        clr(0); dig(0, 0, 7'h12);
        for (int d = 1; d < 8; d++) dig(1, d, 7'h40);
        dig(1, 0, 7'h12);
        check_frame("f6_nolz", 1'b1, 1'b0, '0, 32'h1000_0000, 1'b0);

        for (int d = 0; d < 7; d++) begin
            dig(0, d, 7'h40);
            dig(1, d, 7'h40);
        end
        dig(0, 7, 7'h79); dig(1, 7, 7'h79);
        check_frame("f7_top", 1'b1, 1'b0, '0, 32'h0F00_0000, 1'b0);

        // into slot 3 of the frame showing 0F000000, then async reset
        repeat (14) @(posedge clk);
        @(negedge clk);
        chk("pre_rst", obs_a(), {8'hF7, 1'b1, 7'h40});
        rst = 1'b0;
        #1;
        chk("mid_rst", obs_a(), {8'hFF, 1'b1, 7'h7F});
        chk("mid_rst_nb", obs_b(), {8'hFF, 1'b1, 7'h7F});
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        clr(0); dig(0, 0, 7'h40);
        for (int d = 0; d < 8; d++) dig(1, d, 7'h40);
        check_frame("f_after_rst", 1'b1, 1'b0, '0, 32'h0F00_0000, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
